// File: rtl/counter_regs_pkg.sv
// counter_regs_pkg: shared FunSel encodings and read-select width helper for the counter register bank
package counter_regs_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_reg_cell.sv
// counter_reg_cell: one counter register with sticky overflow/underflow flags
module counter_reg_cell
    import counter_regs_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       fun_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] val,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_V = '1;
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] val_q, val_d, inc_val, dec_val;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             at_max, at_min, ovf_evt, unf_evt;

    // Next value and flags; carry/borrow come from comparing against the bounds, and a new event beats flag_clr
    always_comb begin
        at_max  = (val_q == MAX_V);
        at_min  = (val_q == '0);
        inc_val = at_max ? (SATURATE ? val_q : '0) : val_q + ONE_V;
        dec_val = at_min ? (SATURATE ? val_q : MAX_V) : val_q - ONE_V;
        ovf_evt = en && (fun_sel == FS_INC) && at_max;
        unf_evt = en && (fun_sel == FS_DEC) && at_min;
        val_d   = !en                  ? val_q   :
                  (fun_sel == FS_DEC)  ? dec_val :
                  (fun_sel == FS_INC)  ? inc_val :
                  (fun_sel == FS_LOAD) ? din     : '0;
        ovf_d   = ovf_evt || (ovf_q && !flag_clr);
        unf_d   = unf_evt || (unf_q && !flag_clr);
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            val_q <= val_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign val = val_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule

// File: rtl/counter_register_bank.sv
// counter_register_bank: bank of enable-selected counter registers with two combinational read ports
module counter_register_bank
    import counter_regs_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter bit SATURATE = 1'b0,
    localparam int SELW    = sel_width(NUM_REGS)
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [NUM_REGS-1:0]       E,
    input  logic [1:0]                FunSel,
    input  logic [WIDTH-1:0]          I,
    input  logic                      FlagClr,
    input  logic [SELW-1:0]           OutASel,
    input  logic [SELW-1:0]           OutBSel,
    output logic [WIDTH-1:0]          OutA,
    output logic [WIDTH-1:0]          OutB,
    output logic [NUM_REGS*WIDTH-1:0] Q,
    output logic [NUM_REGS-1:0]       Ovf,
    output logic [NUM_REGS-1:0]       Unf,
    output logic [NUM_REGS-1:0]       Zero
);

    logic [WIDTH-1:0] val [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        counter_reg_cell #(
            .WIDTH   (WIDTH),
            .SATURATE(SATURATE)
        ) u_cell (
            .clk     (Clock),
            .rst_n   (Reset_n),
            .en      (E[k]),
            .fun_sel (FunSel),
            .din     (I),
            .flag_clr(FlagClr),
            .val     (val[k]),
            .ovf     (Ovf[k]),
            .unf     (Unf[k])
        );
        assign Q[k*WIDTH +: WIDTH] = val[k];
        assign Zero[k]             = (val[k] == '0);
    end

    // Read muxes; selects beyond the last register match nothing and read as 0
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (OutASel == SELW'(r)) OutA = val[r];
            if (OutBSel == SELW'(r)) OutB = val[r];
        end
    end

endmodule

// File: doc/counter_register_bank.md
COUNTER_REGISTER_BANK -- requirements
Module: counter_register_bank

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, as the bit width of each register.
REQ-002 The block SHALL provide parameter NUM_REGS, default 4, as the number of registers (range 2..16).
REQ-003 The block SHALL provide parameter SATURATE, default 0: 0 means increment/decrement wrap; 1 means they clamp.
REQ-004 The block SHALL provide port Clock, input, 1 bit: single clock, and all state SHALL update on its rising edge.
REQ-005 The block SHALL provide port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL provide port E, input, NUM_REGS bits: per-register enable, with bit k selecting register k.
REQ-007 The block SHALL provide port FunSel, input, 2 bits: operation shared by all enabled registers.
REQ-008 The block SHALL provide port I, input, WIDTH bits: load data.
REQ-009 The block SHALL provide port FlagClr, input, 1 bit: synchronous clear of all sticky flags.
REQ-010 The block SHALL provide ports OutASel and OutBSel, input, SELW = max(1, clog2(NUM_REGS)) bits each: read-port selects.
REQ-011 The block SHALL provide ports OutA and OutB, output, WIDTH bits each: combinational read data.
REQ-012 The block SHALL provide port Q, output, NUM_REGS*WIDTH bits: all registers flattened, with register k at bits [k*WIDTH +: WIDTH].
REQ-013 The block SHALL provide ports Ovf and Unf, output, NUM_REGS bits each: sticky per-register overflow and underflow flags.
REQ-014 The block SHALL provide port Zero, output, NUM_REGS bits: combinational, and bit k SHALL be 1 when register k equals 0.

Function
REQ-015 FunSel encoding SHALL be: 00 decrement by 1; 01 increment by 1; 10 load I; 11 clear to 0.
REQ-016 Each register with E[k]=1 SHALL apply FunSel at the rising edge, and each register with E[k]=0 SHALL hold its value.
REQ-017 Multiple E bits set SHALL apply the same FunSel to every selected register in the same cycle.
REQ-018 Increment at all-ones SHALL set Ovf[k] and SHALL yield 0 when SATURATE=0, or hold all-ones when SATURATE=1.
REQ-019 Decrement at 0 SHALL set Unf[k] and SHALL yield all-ones when SATURATE=0, or hold 0 when SATURATE=1.
REQ-020 Load and clear SHALL never modify Ovf or Unf.
REQ-021 Ovf and Unf SHALL remain set until FlagClr=1 at a rising edge clears all flags.
REQ-022 When FlagClr=1 in the same cycle as a new overflow or underflow event on register k, the corresponding flag bit SHALL be 1 after the edge (set wins).
REQ-023 Register update latency SHALL be one cycle: the new value SHALL be visible on Q, OutA and OutB immediately after the edge.
REQ-024 OutA and OutB SHALL be combinational muxes of the current register values, with no added latency.
REQ-025 A select value of NUM_REGS or more SHALL drive 0 on the corresponding read port.
REQ-026 OutASel and OutBSel SHALL be allowed to be equal, and both read ports SHALL then return the same value.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, unsigned; the carry and borrow detection SHALL use compare-to-bound and SHALL not use a widened adder output.

Reset
REQ-028 Reset_n=0 SHALL immediately, without waiting for Clock, force all registers, Ovf and Unf to 0, which drives Zero to all ones.
REQ-029 Reset asserted in the middle of operation SHALL override E, FunSel and FlagClr.
REQ-030 After Reset_n deasserts, the first rising edge SHALL be a normal operating edge.

Structure
REQ-031 The FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLR) SHALL be defined as constants in the shared package counter_regs_pkg.
REQ-032 The per-register value and flag logic SHALL be implemented in one sub-module, counter_reg_cell, instantiated NUM_REGS times through generate.
REQ-033 The read muxes and the Q/Zero concatenation SHALL be implemented in the top level.

Verification
REQ-034 Scenario 1: reset, then load 16'h1234 into register 2 (E=0100, FunSel=10) -> Q[47:32]=1234, other registers 0, and OutASel=2 gives OutA=1234.
REQ-035 Scenario 2: with SATURATE=0, load FFFF into register 0 then increment -> register 0 becomes 0000, Ovf[0]=1 and Zero[0]=1; a following load of 5 leaves Ovf[0]=1.
REQ-036 Scenario 3: with SATURATE=1, decrement register 1 at 0 twice -> register 1 stays 0000 and Unf[1]=1; increment at FFFF holds FFFF and sets Ovf[1].
REQ-037 Scenario 4: E=1111, FunSel=01 for 3 cycles from reset -> all registers equal 3; then FunSel=11 with E=0101 -> registers 0 and 2 are 0, registers 1 and 3 are 3.
REQ-038 Scenario 5: FlagClr=1 in the same cycle as a wrapping increment of register 3 -> Ovf[3]=1 after the edge and every other flag is 0.
REQ-039 Scenario 6: assert Reset_n=0 midway between edges while counting -> outputs are 0 before the next edge; with NUM_REGS=3, OutBSel=3 -> OutB=0.
